// File: rtl/pipeline_mem_access.sv
// -----------------------------------------------------------------------------
// pipeline_mem_access
//   Memory-access stage of the 5-stage pipeline. Accepts one instruction per
//   cycle from the execute/memory register. Loads and stores become a
//   request/acknowledge transaction on the data-memory bus. Store data is
//   replicated into byte lanes, and load data is sign- or zero-extended.
//   Upstream stages are held with stall_o while a transaction is outstanding.
//   Misaligned accesses, illegal funct3 values and bus timeouts produce a
//   faulting writeback pulse instead of reaching memory.
//
//   Bus handshake: dmem_req_o is high for every WAIT cycle, and all dmem_*
//   outputs stay stable while it is high. A transfer completes in the first
//   cycle in which dmem_req_o and dmem_ack_i are both high. dmem_ack_i is
//   ignored when no request is outstanding.
//
// Ports
//   clk_i, reset_i       clock; asynchronous active-low reset
//   valid_i ... pc_i     instruction bundle from execute/memory
//   dmem_*_i / dmem_*_o  data-memory bus
//   stall_o              hold all upstream stages
//   wb_*_o, fault*_o     registered writeback bundle (one-cycle pulse)
//   dbg_state_o          FSM state (0 IDLE, 1 WAIT)
// -----------------------------------------------------------------------------
module pipeline_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  input  logic [1:0]  dmem_to_reg_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_reg_write_o,
  output logic [31:0] wb_data_o,
  output logic        fault_o,
  output logic [1:0]  fault_code_o,
  output logic        dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [9:0] LAST_CNT = 10'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next_state;
  logic [9:0]  r_cnt;
  logic [31:0] r_addr, r_pc, r_wdata;
  logic [2:0]  r_funct3;
  logic        r_we, r_reg_write;
  logic [3:0]  r_be;
  logic [4:0]  r_rd;
  logic [1:0]  r_sel;

  logic        r_wb_valid, r_wb_reg_write, r_fault;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic [1:0]  r_fault_code;

  // Decode of the incoming instruction; both read and write high counts as a load.
  logic        w_is_load, w_is_store, w_is_mem, w_f3_ok, w_align_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_is_load  = mem_read_i;
  assign w_is_store = mem_write_i & ~mem_read_i;
  assign w_is_mem   = w_is_load | w_is_store;

  always_comb begin
    w_f3_ok = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = w_is_load;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_align_ok = 1'b1;
    case (funct3_i[1:0])
      2'b01:   w_align_ok = ~alu_result_i[0];
      2'b10:   w_align_ok = (alu_result_i[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (w_is_store) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << alu_result_i[1:0];
          w_wdata = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << alu_result_i[1:0];
          w_wdata = {2{store_data_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = store_data_i;
        end
      endcase
    end
  end

  // Load extraction uses the latched low address bits of the outstanding access.
  logic [31:0] w_byte_sh, w_half_sh, w_load_data;
  assign w_byte_sh = dmem_rdata_i >> {r_addr[1:0], 3'b000};
  assign w_half_sh = dmem_rdata_i >> {r_addr[1], 4'b0000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      3'b001:  w_load_data = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      3'b100:  w_load_data = {24'h0, w_byte_sh[7:0]};
      3'b101:  w_load_data = {16'h0, w_half_sh[15:0]};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  function automatic logic [31:0] wb_mux(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] pc, input logic [31:0] ld);
    case (sel)
      2'b01:   wb_mux = ld;
      2'b10:   wb_mux = pc + 32'd4;
      default: wb_mux = alu;
    endcase
  endfunction

  logic        w_latch, w_stall;
  logic        w_wb_valid_d, w_wb_reg_write_d, w_fault_d;
  logic [4:0]  w_wb_rd_d;
  logic [31:0] w_wb_data_d;
  logic [1:0]  w_fault_code_d;

  always_comb begin
    w_next_state     = r_state;
    w_latch          = 1'b0;
    w_stall          = 1'b0;
    w_wb_valid_d     = 1'b0;
    w_wb_rd_d        = r_wb_rd;
    w_wb_reg_write_d = r_wb_reg_write;
    w_wb_data_d      = r_wb_data;
    w_fault_d        = 1'b0;
    w_fault_code_d   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          if (!w_is_mem) begin
            w_wb_valid_d     = 1'b1;
            w_wb_rd_d        = rd_i;
            w_wb_reg_write_d = reg_write_i;
            w_wb_data_d      = wb_mux(dmem_to_reg_i, alu_result_i, pc_i, 32'h0);
          end else if (!(w_f3_ok && w_align_ok)) begin
            w_wb_valid_d     = 1'b1;
            w_wb_rd_d        = rd_i;
            w_wb_reg_write_d = 1'b0;
            w_wb_data_d      = 32'h0;
            w_fault_d        = 1'b1;
            w_fault_code_d   = 2'b01;
          end else begin
            w_latch      = 1'b1;
            w_stall      = 1'b1;
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          w_wb_valid_d     = 1'b1;
          w_wb_rd_d        = r_rd;
          w_wb_reg_write_d = r_reg_write;
          w_wb_data_d      = wb_mux(r_sel, r_addr, r_pc, w_load_data);
          w_next_state     = S_IDLE;
        end else if (r_cnt == LAST_CNT) begin
          // Final request cycle: drop the stall so upstream advances with the fault.
          w_wb_valid_d     = 1'b1;
          w_wb_rd_d        = r_rd;
          w_wb_reg_write_d = 1'b0;
          w_wb_data_d      = 32'h0;
          w_fault_d        = 1'b1;
          w_fault_code_d   = 2'b10;
          w_next_state     = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt          <= 10'd0;
      r_addr         <= 32'h0;
      r_pc           <= 32'h0;
      r_wdata        <= 32'h0;
      r_funct3       <= 3'b000;
      r_we           <= 1'b0;
      r_reg_write    <= 1'b0;
      r_be           <= 4'b0000;
      r_rd           <= 5'd0;
      r_sel          <= 2'b00;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= 32'h0;
      r_fault        <= 1'b0;
      r_fault_code   <= 2'b00;
    end else begin
      if (r_state == S_WAIT && w_next_state == S_WAIT) r_cnt <= r_cnt + 10'd1;
      else                                             r_cnt <= 10'd0;
      if (w_latch) begin
        r_addr      <= alu_result_i;
        r_pc        <= pc_i;
        r_wdata     <= w_wdata;
        r_funct3    <= funct3_i;
        r_we        <= w_is_store;
        r_reg_write <= reg_write_i;
        r_be        <= w_be;
        r_rd        <= rd_i;
        r_sel       <= dmem_to_reg_i;
      end
      r_wb_valid     <= w_wb_valid_d;
      r_wb_reg_write <= w_wb_reg_write_d;
      r_wb_rd        <= w_wb_rd_d;
      r_wb_data      <= w_wb_data_d;
      r_fault        <= w_fault_d;
      r_fault_code   <= w_fault_code_d;
    end
  end

  assign dmem_req_o     = (r_state == S_WAIT);
  assign dmem_we_o      = r_we;
  assign dmem_addr_o    = {r_addr[31:2], 2'b00};
  assign dmem_wdata_o   = r_wdata;
  assign dmem_be_o      = r_be;
  assign stall_o        = w_stall;
  assign wb_valid_o     = r_wb_valid;
  assign wb_rd_o        = r_wb_rd;
  assign wb_reg_write_o = r_wb_reg_write;
  assign wb_data_o      = r_wb_data;
  assign fault_o        = r_fault;
  assign fault_code_o   = r_fault_code;
  assign dbg_state_o    = r_state;

endmodule
